// File: rtl/seq_multiplier_pkg.sv
// Shared constants for the seq_multiplier block: state encoding and the
// default operand/product widths used alongside the A/B/O register file.
package seq_multiplier_pkg;

    localparam int DEFAULT_INPUT_WIDTH  = 4;
    localparam int DEFAULT_OUTPUT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/seq_multiplier_datapath.sv
// Shift-and-add datapath: accumulator, shifting multiplicand/multiplier and
// step counter, driven by load/step controls from the seq_multiplier FSM.
module mult_datapath
    import seq_multiplier_pkg::*;
#(
    parameter int INPUT_WIDTH  = DEFAULT_INPUT_WIDTH,
    parameter int OUTPUT_WIDTH = DEFAULT_OUTPUT_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic                    step,
    input  logic [INPUT_WIDTH-1:0]  a_in,
    input  logic [INPUT_WIDTH-1:0]  b_in,
    output logic [OUTPUT_WIDTH-1:0] acc,
    output logic                    last_step
);

    localparam int CNT_WIDTH = (INPUT_WIDTH > 1) ? $clog2(INPUT_WIDTH) : 1;

    logic [OUTPUT_WIDTH-1:0] mcand;
    logic [INPUT_WIDTH-1:0]  mplier;
    logic [CNT_WIDTH-1:0]    cnt;

    // Each step consumes one multiplier bit; acc holds between transactions.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= {{(OUTPUT_WIDTH-INPUT_WIDTH){1'b0}}, a_in};
            mplier <= b_in;
            cnt    <= '0;
        end else if (step) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_WIDTH'(1);
        end
    end

    assign last_step = (cnt == CNT_WIDTH'(INPUT_WIDTH-1));

endmodule

// File: rtl/seq_multiplier.sv
// Sequential unsigned multiplier: accepts A/B on start, iterates one partial
// product per cycle, then pulses done to load the product into the O register.
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int INPUT_WIDTH  = DEFAULT_INPUT_WIDTH,
    parameter int OUTPUT_WIDTH = DEFAULT_OUTPUT_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [INPUT_WIDTH-1:0]  a_in,
    input  logic [INPUT_WIDTH-1:0]  b_in,
    output logic                    busy,
    output logic                    done,
    output logic [OUTPUT_WIDTH-1:0] product
);

    generate
        if (OUTPUT_WIDTH != 2*INPUT_WIDTH) begin : g_width_check
            $error("seq_multiplier: OUTPUT_WIDTH must equal 2*INPUT_WIDTH");
        end
    endgenerate

    state_t state;
    logic   load;
    logic   step;
    logic   last_step;

    assign load = (state == IDLE) && start;
    assign step = (state == RUN);

    mult_datapath #(
        .INPUT_WIDTH (INPUT_WIDTH),
        .OUTPUT_WIDTH(OUTPUT_WIDTH)
    ) u_datapath (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .step     (step),
        .a_in     (a_in),
        .b_in     (b_in),
        .acc      (product),
        .last_step(last_step)
    );

    // busy and done are registered alongside the state so they track it exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (last_step) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed corners plus randomized
// transactions compared against a plain a*b reference with fixed latency.
module tb_seq_multiplier;

    localparam int IW      = 4;
    localparam int OW      = 8;
    localparam int LATENCY = IW + 1;

    logic          clk;
    logic          reset;
    logic          start;
    logic [IW-1:0] a_in;
    logic [IW-1:0] b_in;
    logic          busy;
    logic          done;
    logic [OW-1:0] product;

    int errors = 0;
    int checks = 0;

    seq_multiplier #(
        .INPUT_WIDTH (IW),
        .OUTPUT_WIDTH(OW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a_in   (a_in),
        .b_in   (b_in),
        .busy   (busy),
        .done   (done),
        .product(product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One full transaction; optional noise on start/operands while the unit is busy.
    task automatic applyStimulus(input int a, input int b, input bit noisy, input string tag);
        int expected;
        expected = (a * b) & 8'hFF;
        start = 1'b1;
        a_in  = IW'(a);
        b_in  = IW'(b);
        tick();
        start = 1'b0;
        for (int c = 1; c < LATENCY; c++) begin
            checkOutput({tag, " busy run"}, busy, 1);
            checkOutput({tag, " done run"}, done, 0);
            if (noisy) begin
                start = 1'($urandom_range(0, 1));
                a_in  = IW'($urandom_range(0, 15));
                b_in  = IW'($urandom_range(0, 15));
            end
            tick();
        end
        checkOutput({tag, " done pulse"}, done, 1);
        checkOutput({tag, " busy done"}, busy, 1);
        checkOutput({tag, " product"}, product, expected);
        tick();
        start = 1'b0;
        checkOutput({tag, " done cleared"}, done, 0);
        checkOutput({tag, " busy cleared"}, busy, 0);
        checkOutput({tag, " product hold"}, product, expected);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        tick();
        tick();
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset product", product, 0);
        reset = 1'b0;
        tick();

        applyStimulus(13, 11, 1'b0, "basic 13x11");
        tick();
        checkOutput("basic hold idle", product, 143);
        checkOutput("basic idle done", done, 0);

        applyStimulus(0, 15, 1'b0, "corner 0x15");
        applyStimulus(15, 0, 1'b0, "corner 15x0");
        applyStimulus(15, 15, 1'b0, "corner 15x15");
        applyStimulus(1, 1, 1'b0, "corner 1x1");

        // Ignored start during RUN/DONE and operand changes after accept.
        start = 1'b1; a_in = 4'd7; b_in = 4'd3;
        tick();
        start = 1'b0; a_in = 4'd9; b_in = 4'd12;
        tick();
        start = 1'b1; a_in = 4'd2; b_in = 4'd2;
        tick();
        start = 1'b0; a_in = 4'd15; b_in = 4'd1;
        tick();
        tick();
        checkOutput("ignore done pulse", done, 1);
        checkOutput("ignore product", product, 21);
        start = 1'b1; a_in = 4'd2; b_in = 4'd2;
        tick();
        start = 1'b0;
        checkOutput("ignore idle busy", busy, 0);
        for (int c = 0; c < 8; c++) begin
            tick();
            checkOutput("ignore no second done", done, 0);
            checkOutput("ignore no restart", busy, 0);
        end
        checkOutput("ignore product kept", product, 21);

        // Back-to-back with start held high.
        start = 1'b1; a_in = 4'd5; b_in = 4'd6;
        tick();
        a_in = 4'd9; b_in = 4'd9;
        for (int c = 1; c < LATENCY; c++) tick();
        checkOutput("b2b first done", done, 1);
        checkOutput("b2b first product", product, 30);
        tick();
        checkOutput("b2b gap busy", busy, 0);
        checkOutput("b2b gap done", done, 0);
        tick();
        start = 1'b0;
        checkOutput("b2b second accept", busy, 1);
        for (int c = 1; c < LATENCY; c++) begin
            checkOutput("b2b second pending", done, 0);
            tick();
        end
        checkOutput("b2b second done", done, 1);
        checkOutput("b2b second product", product, 81);
        tick();
        tick();

        // Reset in cycle 3 of a 15x15 transaction.
        start = 1'b1; a_in = 4'd15; b_in = 4'd15;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("midreset busy", busy, 0);
        checkOutput("midreset done", done, 0);
        checkOutput("midreset product", product, 0);
        for (int c = 0; c < LATENCY + 2; c++) begin
            tick();
            checkOutput("midreset no done", done, 0);
        end
        applyStimulus(4, 4, 1'b0, "after reset 4x4");

        // Reset and start together: reset wins.
        reset = 1'b1; start = 1'b1; a_in = 4'd3; b_in = 4'd3;
        tick();
        reset = 1'b0; start = 1'b0;
        checkOutput("reset+start busy", busy, 0);
        checkOutput("reset+start product", product, 0);
        tick();
        checkOutput("reset+start no accept", busy, 0);
        checkOutput("reset+start no done", done, 0);

        // Randomized transactions with noisy inputs while busy.
        for (int t = 0; t < 25; t++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) tick();
            applyStimulus($urandom_range(0, 15), $urandom_range(0, 15), 1'b1, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: observed=1 expected=0");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Unsigned shift-and-add multiplier that sits downstream of the A/B operand registers and upstream of the O result register. It consumes the 4-bit A and B register outputs on a start pulse and iterates one partial product per cycle. It then presents the 8-bit product with a one-cycle load strobe that drives the O register's load enable. Fixed latency, single transaction in flight, start/done handshake to the control unit.

## Interface
- INPUT_WIDTH, 4, operand width (A, B)
- OUTPUT_WIDTH, 8, product width; must equal 2*INPUT_WIDTH
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- start  in  1  request; sampled only in IDLE
- a_in  in  INPUT_WIDTH  multiplicand (from A register output)
- b_in  in  INPUT_WIDTH  multiplier (from B register output)
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse, product valid; wire to O register load enable
- product  out  OUTPUT_WIDTH  result; feeds O register data input

## Operation
- Unsigned arithmetic only; max result 15*15 = 225 fits 8 bits, no overflow path.
- Internal registers: acc (OUTPUT_WIDTH), mcand (OUTPUT_WIDTH, a_in zero-extended), mplier (INPUT_WIDTH), cnt (clog2(INPUT_WIDTH) bits).
- FSM, 3 states:
  - IDLE: start=1 -> capture mcand={0,a_in}, mplier=b_in, acc=0, cnt=0; go RUN. start=0 -> stay. acc/product hold.
  - RUN: per cycle, if mplier[0]: acc <= acc + mcand. Also mcand <= mcand<<1, mplier <= mplier>>1, cnt <= cnt+1. When cnt == INPUT_WIDTH-1 this cycle, go DONE.
  - DONE: done=1 for exactly this cycle; go IDLE unconditionally.
- product = acc. It is meaningful when done=1 and holds its value in IDLE until the next accepted start.
- No early termination on zero operands; latency is always fixed.
- start in RUN or DONE is ignored and not queued.
- a_in/b_in are sampled only at the accepting edge; later changes have no effect.

## Timing
- Reset values: state=IDLE, busy=0, done=0, product=0, acc=mcand=mplier=cnt=0.
- start high in cycle 0 (IDLE) -> busy high in cycles 1..INPUT_WIDTH+1. RUN occupies cycles 1..4; DONE is cycle 5 with done=1 and product valid.
- Latency from start to done is INPUT_WIDTH+1 cycles (5 at default). Throughput is one product per INPUT_WIDTH+2 cycles.
- The earliest next accept is the cycle after DONE (IDLE). start held high continuously re-triggers there.
- The O register captures product on the edge ending the DONE cycle.
- Reset mid-operation (RUN or DONE) has priority over everything. The next cycle is IDLE with all outputs at reset values, and no done pulse is produced.
- Reset and start together: reset wins; start is not accepted.

## Structure
- Shared package: state encoding constants (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the default INPUT_WIDTH/OUTPUT_WIDTH constants shared with the register file.
- One natural sub-module: mult_datapath. It holds acc/mcand/mplier/cnt with load and step controls and outputs last_step (cnt == INPUT_WIDTH-1).
- The FSM, busy and done logic stay in seq_multiplier top.
- Elaboration check: error if OUTPUT_WIDTH != 2*INPUT_WIDTH.

## Test plan
- Basic: a=13, b=11, 1-cycle start -> done pulses exactly 5 cycles later with product=143 (0x8F). busy is high for 5 cycles, then product holds 0x8F in IDLE.
- Corners: a=0,b=15 -> 0; a=15,b=0 -> 0; a=15,b=15 -> 225 (0xE1); a=1,b=1 -> 1. All at fixed 5-cycle latency.
- Ignored start and operand change: start 7*3 -> 21. Re-pulse start with a=2,b=2 in cycles 2 and 5, and change a_in/b_in during RUN -> single done with product=21 and no second done.
- Back-to-back: hold start high with a=5,b=6, then switch to a=9,b=9 after the first accept -> done pulses with 30, then 81. The second accept is in the cycle after the first DONE, so done pulses are 6 cycles apart.
- Reset mid-op: start 15*15, assert reset in cycle 3 -> next cycle busy=0, done=0, product=0. No done pulse follows. A new start of 4*4 then yields 16.
- Reset with start in the same cycle -> no accept; busy stays 0.
